// File: rtl/panda_pkg.sv
// Shared definitions for the Panda fetch-path blocks.
package panda_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic {MemLoad, MemRun} instr_mem_state_e;

endpackage

// File: rtl/panda_ram_1r1w.sv
// Word array with one combinational read port and one synchronous write port; no reset.
module panda_ram_1r1w #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/panda_instr_mem.sv
// Instruction memory for the Panda fetch stage: boot-load stream fills the array,
// load/run FSM holds the core in reset until the load completes.
module panda_instr_mem
  import panda_pkg::*;
#(
  parameter int unsigned Depth    = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  localparam int unsigned IdxW    = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_addr_i,
  output logic [31:0]     instr_rdata_o,
  output logic            instr_err_o,
  input  logic            load_valid_i,
  input  logic [31:0]     load_data_i,
  input  logic            load_last_i,
  output logic            load_ready_o,
  input  logic            load_start_i,
  output logic            core_rst_o,
  output logic [IdxW:0]   load_count_o
);

  localparam logic [IdxW:0] LastIdx = (IdxW+1)'(Depth - 1);
  localparam logic [IdxW:0] CntOne  = (IdxW+1)'(1);

  instr_mem_state_e r_state;
  logic [IdxW:0]    r_count;

  logic            w_we;
  logic [31:0]     w_off;
  logic [31:0]     w_word;
  logic            w_in_range;
  logic [31:0]     w_ram_rdata;

  // A reset edge must never write, even if a transfer is presented on it.
  assign w_we = (r_state == MemLoad) && load_valid_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= MemLoad;
      r_count <= '0;
    end else begin
      case (r_state)
        MemLoad: begin
          if (load_valid_i) begin
            r_count <= r_count + CntOne;
            if (load_last_i || (r_count == LastIdx)) begin
              r_state <= MemRun;
            end
          end
        end
        MemRun: begin
          if (load_start_i) begin
            r_state <= MemLoad;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= MemLoad;
          r_count <= '0;
        end
      endcase
    end
  end

  assign w_off      = instr_addr_i - BaseAddr;
  assign w_word     = w_off >> 2;
  assign w_in_range = (instr_addr_i >= BaseAddr) && (w_word < 32'(Depth));

  panda_ram_1r1w #(
    .Depth (Depth),
    .Width (32)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (r_count[IdxW-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (w_word[IdxW-1:0]),
    .rdata_o (w_ram_rdata)
  );

  always_comb begin
    instr_rdata_o = NopInstr;
    instr_err_o   = 1'b0;
    if (!w_in_range) begin
      instr_err_o = 1'b1;
    end else if (r_state == MemRun) begin
      instr_rdata_o = w_ram_rdata;
    end
  end

  assign load_ready_o = (r_state == MemLoad);
  assign core_rst_o   = (r_state == MemLoad);
  assign load_count_o = r_count;

endmodule

// File: tb/tb_panda_instr_mem.sv
// Directed bench for panda_instr_mem (Depth=4, BaseAddr=0x100) with a read scoreboard.
module tb_panda_instr_mem;

  localparam int unsigned Depth    = 4;
  localparam logic [31:0] BaseAddr = 32'h0000_0100;
  localparam logic [31:0] Nop      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        load_last_i;
  logic        load_ready_o;
  logic        load_start_i;
  logic        core_rst_o;
  logic [2:0]  load_count_o;

  panda_instr_mem #(
    .Depth    (Depth),
    .BaseAddr (BaseAddr)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_addr_i  (instr_addr_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .load_valid_i  (load_valid_i),
    .load_data_i   (load_data_i),
    .load_last_i   (load_last_i),
    .load_ready_o  (load_ready_o),
    .load_start_i  (load_start_i),
    .core_rst_o    (core_rst_o),
    .load_count_o  (load_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Handshake reference: spec-level load/run behaviour.
  bit m_load;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit s, input bit r,
                     input string tag);
    @(negedge clk_i);
    load_valid_i = v; load_data_i = d; load_last_i = l; load_start_i = s; rst_i = r;
    #1;
    chk({tag, "_ready"}, 32'(load_ready_o), 32'(m_load));
    chk({tag, "_corerst"}, 32'(core_rst_o), 32'(m_load));
    chk({tag, "_count"}, 32'(load_count_o), 32'(m_count));
    if (r) begin
      m_load = 1'b1; m_count = 0;
    end else if (m_load) begin
      if (v) begin
        m_count++;
        if (l || m_count == Depth) m_load = 1'b0;
      end
    end else if (s) begin
      m_load = 1'b1; m_count = 0;
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] d, input logic e, input string tag);
    exp_t x;
    exp_q.push_back('{data: d, err: e, tag: tag});
    @(negedge clk_i);
    load_valid_i = 1'b0; load_start_i = 1'b0; rst_i = 1'b0; load_last_i = 1'b0;
    instr_addr_i = addr;
    #1;
    x = exp_q.pop_front();
    chk({x.tag, "_rdata"}, instr_rdata_o, x.data);
    chk({x.tag, "_err"}, 32'(instr_err_o), 32'(x.err));
  endtask

  initial begin
    rst_i = 1'b1; load_valid_i = 1'b0; load_data_i = '0; load_last_i = 1'b0;
    load_start_i = 1'b0; instr_addr_i = BaseAddr;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_load = 1'b1; m_count = 0;

    // Reset state and reads while loading
    cyc(0, '0, 0, 0, 0, "rst_idle");
    rd(BaseAddr, Nop, 1'b0, "load_inrange");
    rd(32'h0000_00FC, Nop, 1'b1, "load_below");

    // Basic 4-word load with last on the 4th
    cyc(1, 32'd13, 0, 0, 0, "ld0");
    cyc(1, 32'd93, 0, 0, 0, "ld1");
    cyc(1, 32'd113, 0, 0, 0, "ld2");
    cyc(1, 32'h0010_0073, 1, 0, 0, "ld3");
    cyc(0, '0, 0, 0, 0, "run_after_ld");
    chk("count_after_ld", 32'(load_count_o), 32'd4);
    rd(BaseAddr + 0, 32'd13, 1'b0, "w0");
    rd(BaseAddr + 4, 32'd93, 1'b0, "w1");
    rd(BaseAddr + 8, 32'd113, 1'b0, "w2");
    rd(BaseAddr + 12, 32'h0010_0073, 1'b0, "w3");
    rd(BaseAddr + 16, Nop, 1'b1, "past_end");
    rd(32'h0000_00FC, Nop, 1'b1, "below_base");
    rd(BaseAddr + 6, 32'd93, 1'b0, "unaligned");

    // Valid in RUN is ignored
    cyc(1, 32'hDEAD_BEEF, 1, 0, 0, "run_valid");
    rd(BaseAddr, 32'd13, 1'b0, "run_nowrite");

    // load_start together with valid: no write on that edge
    cyc(1, 32'hBAD0_BAD0, 0, 1, 0, "start");
    cyc(0, '0, 0, 0, 0, "after_start");
    rd(BaseAddr, Nop, 1'b0, "reload_nop");

    // Toggling valid, no last: fills to Depth and auto-runs
    cyc(1, 32'hA000_0000, 0, 0, 0, "tg0");
    cyc(0, 32'hFFFF_FFFF, 0, 0, 0, "tg0i");
    cyc(1, 32'hA000_0001, 0, 0, 0, "tg1");
    cyc(0, 32'hFFFF_FFFF, 1, 0, 0, "tg1i");
    cyc(1, 32'hA000_0002, 0, 0, 0, "tg2");
    cyc(0, 32'hFFFF_FFFF, 0, 0, 0, "tg2i");
    cyc(1, 32'hA000_0003, 0, 0, 0, "tg3");
    cyc(1, 32'hA000_0004, 1, 0, 0, "tg_fifth");
    chk("count_full", 32'(load_count_o), 32'd4);
    rd(BaseAddr + 0, 32'hA000_0000, 1'b0, "tw0");
    rd(BaseAddr + 4, 32'hA000_0001, 1'b0, "tw1");
    rd(BaseAddr + 8, 32'hA000_0002, 1'b0, "tw2");
    rd(BaseAddr + 12, 32'hA000_0003, 1'b0, "tw3");

    // Reset mid-load, transfer on the reset edge is dropped
    cyc(0, '0, 0, 1, 0, "start2");
    cyc(1, 32'hB000_0000, 0, 0, 0, "b0");
    cyc(1, 32'hB000_0001, 0, 0, 0, "b1");
    cyc(1, 32'hB000_0002, 0, 0, 1, "b2_rst");
    cyc(1, 32'hC000_0000, 1, 0, 0, "c0");
    cyc(0, '0, 0, 0, 0, "after_c0");
    rd(BaseAddr + 0, 32'hC000_0000, 1'b0, "rw0");
    rd(BaseAddr + 4, 32'hB000_0001, 1'b0, "rw1");
    rd(BaseAddr + 8, 32'hA000_0002, 1'b0, "rw2");
    rd(BaseAddr + 12, 32'hA000_0003, 1'b0, "rw3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
